// File: rtl/sampling_scheduler_if.sv
`default_nettype none
// ============================================================================
//  Module   : sampling_scheduler_if
//  Purpose  : Bundle of the signals between the sampling scheduler and the
//             PRNG sampler it sequences.
//
//  Signals
//    smp_rst            scheduler -> sampler, active-high synchronous reset
//    smp_sample_errors  scheduler -> sampler, 1 = error phase, 0 = pk1 phase
//    smp_seed[63:0]     scheduler -> sampler, seed for the current phase
//    smp_done           sampler -> scheduler, completion level
//
//  Modports
//    master  : scheduler side (drives reset/select/seed, reads done)
//    slave   : sampler side   (reads reset/select/seed, drives done)
//
//  Revision : 1.0  initial release
// ============================================================================
interface sampling_scheduler_if;
  logic        smp_rst;
  logic        smp_sample_errors;
  logic [63:0] smp_seed;
  logic        smp_done;

  modport master (
    output smp_rst,
    output smp_sample_errors,
    output smp_seed,
    input  smp_done
  );

  modport slave (
    input  smp_rst,
    input  smp_sample_errors,
    input  smp_seed,
    output smp_done
  );
endinterface
`default_nettype wire

// File: rtl/sampling_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : sampling_scheduler
//  Purpose  : Sequences a PRNG sampler through up to two phases per job
//             (pk1, then the error phase e0/e1/v). Each phase holds the
//             sampler in reset for RST_CYCLES cycles with the phase seed and
//             select applied, then runs it until smp_done or a per-phase
//             watchdog expiry.
//
//  Parameters
//    RST_CYCLES  sampler reset cycles per phase (1..15)
//    TIMEOUT_W   width of the per-phase watchdog counter
//
//  Ports
//    clk, rst_n        clock, asynchronous active-low reset
//    start             one-cycle job request (honoured only in IDLE)
//    req_phases[1:0]   bit0 = run pk1 phase, bit1 = run error phase
//    seed_pk1/seed_err per-phase seeds, latched on start
//    abort             cancel the job in progress (no done pulse)
//    smp               sampler bus (master side)
//    busy              job in progress
//    done              one-cycle job-complete pulse
//    timeout           sticky watchdog-expiry flag for the last job
//
//  All outputs are registered: every output register is loaded from the
//  next-state decode, so it lines up with the state it describes.
//
//  Revision : 1.0  initial release
// ============================================================================
module sampling_scheduler #(
  parameter int RST_CYCLES = 2,
  parameter int TIMEOUT_W  = 20
) (
  input  wire logic        clk,
  input  wire logic        rst_n,
  input  wire logic        start,
  input  wire logic [1:0]  req_phases,
  input  wire logic [63:0] seed_pk1,
  input  wire logic [63:0] seed_err,
  input  wire logic        abort,
  sampling_scheduler_if.master smp,
  output logic             busy,
  output logic             done,
  output logic             timeout
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LOAD_PK1 = 3'd1,
    RUN_PK1  = 3'd2,
    LOAD_ERR = 3'd3,
    RUN_ERR  = 3'd4,
    FIN      = 3'd5
  } state_t;

  localparam logic [TIMEOUT_W-1:0] WD_MAX   = '1;
  localparam logic [TIMEOUT_W-1:0] WD_ONE   = 1;
  localparam logic [3:0]           RST_LAST = 4'(RST_CYCLES - 1);

  // --------------------------------------------------------------------------
  // State and datapath registers
  // --------------------------------------------------------------------------
  state_t                state;
  state_t                state_next;

  logic                  err_req_q;    // error phase requested for this job
  logic [63:0]           seed_err_q;   // error-phase seed captured on start
  logic [3:0]            rst_cnt;      // cycles spent in the current LOAD state
  logic [TIMEOUT_W-1:0]  wd;           // per-phase watchdog

  logic                  smp_rst_q;
  logic                  smp_sel_q;
  logic [63:0]           smp_seed_q;
  logic                  busy_q;
  logic                  done_q;
  logic                  timeout_q;

  // --------------------------------------------------------------------------
  // Combinational decode
  // --------------------------------------------------------------------------
  logic                  accept;       // start honoured this cycle
  logic                  load_done;    // last reset cycle of a LOAD state
  logic [TIMEOUT_W-1:0]  wd_inc;       // saturating watchdog increment
  logic                  wd_expire;    // watchdog reaches its maximum this cycle
  logic                  set_timeout;
  logic                  done_next;
  logic                  in_load;
  logic                  in_run;
  logic                  enter_run;

  always_comb begin
    state_next  = state;
    set_timeout = 1'b0;

    accept    = (state == IDLE) && start && !abort;
    load_done = (rst_cnt == RST_LAST);
    wd_inc    = (wd == WD_MAX) ? wd : (wd + WD_ONE);
    wd_expire = (wd_inc == WD_MAX);

    case (state)
      IDLE: begin
        if (accept) begin
          if (req_phases[0])      state_next = LOAD_PK1;
          else if (req_phases[1]) state_next = LOAD_ERR;
          else                    state_next = FIN;
        end
      end

      LOAD_PK1: begin
        if (load_done) state_next = RUN_PK1;
      end

      // smp_done is checked before the watchdog so that a completion landing
      // on the expiry cycle still counts as a success.
      RUN_PK1: begin
        if (smp.smp_done) begin
          state_next = err_req_q ? LOAD_ERR : FIN;
        end else if (wd_expire) begin
          state_next  = FIN;
          set_timeout = 1'b1;
        end
      end

      LOAD_ERR: begin
        if (load_done) state_next = RUN_ERR;
      end

      RUN_ERR: begin
        if (smp.smp_done) begin
          state_next = FIN;
        end else if (wd_expire) begin
          state_next  = FIN;
          set_timeout = 1'b1;
        end
      end

      FIN: begin
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase

    // Abort overrides every other transition, including a same-cycle
    // completion or watchdog expiry, and leaves the timeout flag alone.
    if (abort && (state != IDLE)) begin
      state_next  = IDLE;
      set_timeout = 1'b0;
    end

    in_load   = (state == LOAD_PK1) || (state == LOAD_ERR);
    in_run    = (state == RUN_PK1)  || (state == RUN_ERR);
    enter_run = ((state_next == RUN_PK1) || (state_next == RUN_ERR)) &&
                (state_next != state);

    // done is raised the cycle after FIN; busy stays high through that
    // cycle so the pulse is always framed by busy.
    done_next = (state == FIN) && !abort;
  end

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // --------------------------------------------------------------------------
  // Job capture, LOAD counter and watchdog
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_req_q  <= 1'b0;
      seed_err_q <= 64'd0;
      rst_cnt    <= 4'd0;
      wd         <= '0;
    end else begin
      if (accept) begin
        err_req_q  <= req_phases[1];
        seed_err_q <= seed_err;
      end

      // Counts cycles while staying in a LOAD state; cleared everywhere else
      // so the next LOAD always starts from zero.
      if (in_load && (state_next == state)) begin
        rst_cnt <= rst_cnt + 4'd1;
      end else begin
        rst_cnt <= 4'd0;
      end

      if (enter_run) begin
        wd <= '0;
      end else if (in_run) begin
        wd <= wd_inc;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Sampler-facing outputs
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      smp_rst_q  <= 1'b1;
      smp_sel_q  <= 1'b0;
      smp_seed_q <= 64'd0;
    end else begin
      // The sampler is released only while a RUN state is active.
      smp_rst_q <= !((state_next == RUN_PK1) || (state_next == RUN_ERR));

      // Seed and select are loaded on LOAD entry and then held through RUN.
      // The error seed comes straight from the port when the job starts
      // with the error phase, because the latched copy is written on the
      // same edge.
      if ((state_next == LOAD_PK1) && (state != LOAD_PK1)) begin
        smp_seed_q <= seed_pk1;
        smp_sel_q  <= 1'b0;
      end else if ((state_next == LOAD_ERR) && (state != LOAD_ERR)) begin
        smp_seed_q <= (state == IDLE) ? seed_err : seed_err_q;
        smp_sel_q  <= 1'b1;
      end else if (state_next == IDLE) begin
        smp_sel_q  <= 1'b0;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Job status outputs
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      busy_q <= (state_next != IDLE) || done_next;
      done_q <= done_next;

      if (accept) begin
        timeout_q <= 1'b0;
      end else if (set_timeout) begin
        timeout_q <= 1'b1;
      end
    end
  end

  assign smp.smp_rst           = smp_rst_q;
  assign smp.smp_sample_errors = smp_sel_q;
  assign smp.smp_seed          = smp_seed_q;
  assign busy                  = busy_q;
  assign done                  = done_q;
  assign timeout               = timeout_q;

endmodule
`default_nettype wire
